frame_scan_sequencer: RTL and testbench

//  Sequences the 16x12 frame tracker once per game tick. Steps the tracker cell by cell

---
 rtl/frame_scan_sequencer.sv | 170 +++++++++++++++++
 tb/tb_frame_scan_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scan_sequencer.sv
// Frame scan sequencer: walks the 16x12 frame tracker once per tick and issues one draw per changed cell.
// Optional draw-ack watchdog enabled by defining FRAME_SEQ_TIMEOUT_EN.
module frame_scan_sequencer #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12
`ifdef FRAME_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       tick,
  input  logic       game_reset,
  input  logic       diff,
  input  logic [2:0] obj_code,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       enable,
  output logic       sync,
  output logic       draw_req,
  input  logic       draw_ack,
  output logic [3:0] draw_x,
  output logic [3:0] draw_y,
  output logic [2:0] draw_obj,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun,
  output logic       draw_err
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int CNT_W = $clog2(CELLS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CELLS - 1);

  typedef enum logic [1:0] {IDLE, INIT, SCAN, DRAW} state_t;

  state_t           state;
  logic [CNT_W-1:0] cell_cnt;
  logic             pending;
  logic             grst_pend;
  logic             redraw_all;
  logic             retire_q;
  logic             hit;
  logic             retire;

`ifdef FRAME_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign draw_err = 1'b0;
`endif

  // The tracker advances on the same edge the counter retires a cell, so enable
  // must reflect the cell on view this cycle. After a draw, retire_q forces the
  // retire because the tracker still shows the just-drawn (still differing) cell.
  assign hit    = diff | redraw_all;
  assign retire = (state == SCAN) && (retire_q || !hit);
  assign enable = retire;

  // NOTE: every state register below uses non-blocking assignment so all updates
  // see the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      cell_cnt   <= '0;
      pending    <= 1'b0;
      grst_pend  <= 1'b0;
      redraw_all <= 1'b0;
      retire_q   <= 1'b0;
      sync       <= 1'b0;
      draw_req   <= 1'b0;
      draw_x     <= '0;
      draw_y     <= '0;
      draw_obj   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
`ifdef FRAME_SEQ_TIMEOUT_EN
      wd_cnt     <= '0;
      draw_err   <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      sync       <= 1'b0;

      // Requests arriving mid-frame are remembered one deep.
      if (state != IDLE) begin
        if (tick) begin
          if (pending) overrun <= 1'b1;
          else         pending <= 1'b1;
        end
        if (game_reset) grst_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (game_reset || grst_pend) begin
            state     <= INIT;
            busy      <= 1'b1;
            sync      <= 1'b1;
            grst_pend <= 1'b0;
            if (tick) begin
              if (pending) overrun <= 1'b1;
              else         pending <= 1'b1;
            end
          end else if (tick || pending) begin
            state   <= SCAN;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end

        INIT: begin
          redraw_all <= 1'b1;
          cell_cnt   <= '0;
          state      <= SCAN;
        end

        SCAN: begin
          retire_q <= 1'b0;
          if (retire) begin
            if (cell_cnt == LAST) begin
              cell_cnt   <= '0;
              redraw_all <= 1'b0;
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              cell_cnt <= cell_cnt + 1'b1;
            end
          end else begin
            draw_x   <= x;
            draw_y   <= y;
            draw_obj <= obj_code;
            draw_req <= 1'b1;
            state    <= DRAW;
`ifdef FRAME_SEQ_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
          end
        end

        DRAW: begin
          if (draw_ack) begin
            draw_req <= 1'b0;
            retire_q <= 1'b1;
            state    <= SCAN;
          end
`ifdef FRAME_SEQ_TIMEOUT_EN
          else if (wd_expire) begin
            draw_req <= 1'b0;
            draw_err <= 1'b1;
            retire_q <= 1'b1;
            state    <= SCAN;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scan_sequencer.sv
// Directed bench for frame_scan_sequencer with a behavioural 16x12 tracker and an auto-acking renderer.
// Define FRAME_SEQ_TIMEOUT_EN to also exercise the draw-ack watchdog.
module tb_frame_scan_sequencer;

`ifdef FRAME_SEQ_TIMEOUT_EN
  localparam int LONG_ACK = 7;
`else
  localparam int LONG_ACK = 10;
`endif

  logic       clk = 1'b0;
  logic       nrst;
  logic       tick, game_reset;
  logic       diff;
  logic [2:0] obj_code;
  logic [3:0] x, y;
  logic       enable, sync, draw_req, draw_ack;
  logic [3:0] draw_x, draw_y;
  logic [2:0] draw_obj;
  logic       busy, frame_done, overrun, draw_err;

  frame_scan_sequencer #(
    .GRID_W(16),
    .GRID_H(12)
`ifdef FRAME_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .nrst(nrst), .tick(tick), .game_reset(game_reset),
    .diff(diff), .obj_code(obj_code), .x(x), .y(y),
    .enable(enable), .sync(sync), .draw_req(draw_req), .draw_ack(draw_ack),
    .draw_x(draw_x), .draw_y(draw_y), .draw_obj(draw_obj),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .draw_err(draw_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural frame tracker: per-cell diff and object maps.
  logic [191:0] diff_map;
  logic [2:0]   obj_map [192];
  logic [3:0]   tx, ty;
  int           cell_idx;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx <= '0; ty <= '0;
    end else if (sync) begin
      tx <= '0; ty <= '0;
    end else if (enable) begin
      if (tx == 4'd15) begin
        tx <= '0;
        ty <= (ty == 4'd11) ? 4'd0 : ty + 4'd1;
      end else begin
        tx <= tx + 4'd1;
      end
    end
  end

  assign cell_idx = int'(ty) * 16 + int'(tx);
  assign x        = tx;
  assign y        = ty;
  assign diff     = diff_map[cell_idx];
  assign obj_code = obj_map[cell_idx];

  // Renderer: acks after draw_req has been high ack_delay cycles; 0 never acks.
  int   ack_delay = 0;
  int   age = 0;
  logic ack_q = 1'b0;
  logic stray_ack;
  assign draw_ack = ack_q | stray_ack;

  always @(negedge clk) begin
    if (ack_q) begin
      ack_q = 1'b0;
      age   = 0;
    end else if (draw_req) begin
      age++;
      if (ack_delay != 0 && age >= ack_delay) ack_q = 1'b1;
    end else begin
      age = 0;
    end
  end

  // Monitor: cumulative event counters sampled on the falling edge.
  int   en_cnt = 0, req_cnt = 0, overlap_cnt = 0, sync_cnt = 0, ovr_cnt = 0, done_cnt = 0;
  int   start_cyc = 0, frame_len = 0;
  logic in_frame = 1'b0;
  logic prev_req = 1'b0;
  logic [10:0] draws [$];

  always @(negedge clk) begin
    if (!nrst) in_frame = 1'b0;
    if (enable) begin
      en_cnt++;
      if (!in_frame) begin
        in_frame  = 1'b1;
        start_cyc = cyc;
      end
    end
    if (draw_req) req_cnt++;
    if (enable && draw_req) overlap_cnt++;
    if (sync) sync_cnt++;
    if (overrun) ovr_cnt++;
    if (frame_done) begin
      done_cnt++;
      frame_len = cyc - start_cyc;
      in_frame  = 1'b0;
    end
    if (draw_req && !prev_req) draws.push_back({draw_x, draw_y, draw_obj});
    prev_req = draw_req;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    check(tag, done_cnt, target);
  endtask

  function automatic logic [17:0] out_vec();
    return {enable, sync, draw_req, busy, frame_done, overrun, draw_err, draw_x, draw_y, draw_obj};
  endfunction

  int base_en, base_req, base_ovl, base_sync, base_ovr, base_done, base_draw;

  task automatic snap();
    base_en   = en_cnt;
    base_req  = req_cnt;
    base_ovl  = overlap_cnt;
    base_sync = sync_cnt;
    base_ovr  = ovr_cnt;
    base_done = done_cnt;
    base_draw = draws.size();
  endtask

  initial begin
    int errs;
    int n;
    logic [10:0] d;

    nrst       = 1'b0;
    tick       = 1'b0;
    game_reset = 1'b0;
    stray_ack  = 1'b0;
    diff_map   = '0;
    for (int i = 0; i < 192; i++) obj_map[i] = 3'(i % 7);

    repeat (3) step();
    check("reset_outputs", 32'(out_vec()), 32'd0);
    nrst = 1'b1;
    step();
    check("idle_outputs", 32'(out_vec()), 32'd0);

    // Quiet frame: every cell retired with no draws.
    snap();
    pulse_tick();
    wait_frames(base_done + 1, 1000, "quiet_done");
    check("quiet_enables", en_cnt - base_en, 192);
    check("quiet_no_req", req_cnt - base_req, 0);
    check("quiet_frame_len", frame_len, 192);
    step();
    check("quiet_idle_busy", busy, 0);
    check("quiet_tracker_wrap", {tx, ty}, 8'h00);

    // Ack while idle must do nothing.
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    step();
    check("stray_ack_idle", {busy, enable, draw_req}, 3'b000);

    // Game reset: resync then redraw every cell in sweep order.
    snap();
    ack_delay  = 2;
    game_reset = 1'b1;
    step();
    game_reset = 1'b0;
    wait_frames(base_done + 1, 2000, "redraw_done");
    check("redraw_sync_pulses", sync_cnt - base_sync, 1);
    check("redraw_draw_count", draws.size() - base_draw, 192);
    check("redraw_enables", en_cnt - base_en, 192);
    check("redraw_req_cycles", req_cnt - base_req, 384);
    check("redraw_no_overlap", overlap_cnt - base_ovl, 0);
    errs = 0;
    for (int k = 0; k < 192 && base_draw + k < draws.size(); k++) begin
      d = draws[base_draw + k];
      if (d !== {4'(k % 16), 4'(k / 16), obj_map[k]}) errs++;
    end
    check("redraw_sweep_order", errs, 0);

    // Single diff at (4,4) with a slow ack.
    snap();
    ack_delay     = LONG_ACK;
    diff_map[68]  = 1'b1;
    obj_map[68]   = 3'd5;
    pulse_tick();
    wait_frames(base_done + 1, 1000, "single_done");
    check("single_draw_count", draws.size() - base_draw, 1);
    check("single_req_held", req_cnt - base_req, LONG_ACK);
    check("single_no_overlap", overlap_cnt - base_ovl, 0);
    d = (draws.size() > base_draw) ? draws[base_draw] : 11'h0;
    check("single_draw_xyobj", d, {4'd4, 4'd4, 3'd5});
    check("single_frame_len", frame_len, 192 + 1 + LONG_ACK);

    // Reset while a draw is pending, then a fresh scan from cell 0.
    ack_delay = 0;
    pulse_tick();
    n = 0;
    while (!draw_req && n < 500) begin
      step();
      n++;
    end
    check("midraw_req_seen", draw_req, 1);
    nrst = 1'b0;
    #1;
    check("midraw_reset_outputs", 32'(out_vec()), 32'd0);
    step();
    nrst = 1'b1;
    step();
    check("midraw_after_reset", 32'(out_vec()), 32'd0);
    snap();
    ack_delay = 2;
    pulse_tick();
    wait_frames(base_done + 1, 1000, "rescan_done");
    d = (draws.size() > base_draw) ? draws[base_draw] : 11'h0;
    check("rescan_draw_xyobj", d, {4'd4, 4'd4, 3'd5});
    check("rescan_frame_len", frame_len, 195);

    // Two ticks during a scan: one pending, one overrun, exactly one extra frame.
    diff_map = '0;
    snap();
    pulse_tick();
    repeat (20) step();
    pulse_tick();
    repeat (20) step();
    pulse_tick();
    wait_frames(base_done + 2, 2000, "pending_done");
    check("pending_overrun", ovr_cnt - base_ovr, 1);
    repeat (300) step();
    check("pending_frames", done_cnt - base_done, 2);
    check("pending_enables", en_cnt - base_en, 384);
    check("pending_idle_busy", busy, 0);

`ifdef FRAME_SEQ_TIMEOUT_EN
    // No ack at all: the watchdog abandons the draw and the scan finishes.
    snap();
    ack_delay    = 0;
    diff_map[68] = 1'b1;
    pulse_tick();
    wait_frames(base_done + 1, 1000, "timeout_done");
    check("timeout_req_cycles", req_cnt - base_req, 8);
    check("timeout_enables", en_cnt - base_en, 192);
    check("timeout_err_set", draw_err, 1);
    repeat (10) step();
    check("timeout_err_sticky", draw_err, 1);
`else
    check("no_watchdog_err", draw_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
